// File: rtl/qam_symbol_gen_if.sv
// Control/data bundle between the test-data source and its consumer.
// The slave modport is the generator side; the master modport drives the controls.
interface qam_symbol_gen_if #(
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned PERIOD_W     = 10
);
  logic                    enable_cntr;
  logic                    mode;
  logic [PERIOD_W-1:0]     period;
  logic [BITS_PER_SYM-1:0] sym_out;
  logic                    data_change;
  logic                    frame_start;

  modport master (
    output enable_cntr, mode, period,
    input  sym_out, data_change, frame_start
  );

  modport slave (
    input  enable_cntr, mode, period,
    output sym_out, data_change, frame_start
  );
endinterface

// File: rtl/qam_symbol_gen.sv
// Multi-bit test-symbol source: counts enable rising edges and every period+1
// ticks emits a symbol from a rotating pattern or a PRBS15 (x^15+x^14+1) sequence.
module qam_symbol_gen #(
  parameter int unsigned             BITS_PER_SYM = 2,
  parameter int unsigned             PERIOD_W     = 10,
  parameter int unsigned             PATTERN_LEN  = 28,
  parameter logic [PATTERN_LEN-1:0]  PATTERN      = 28'h6CC1555
) (
  input  logic            clock,
  input  logic            reset,
  qam_symbol_gen_if.slave bus
);
  localparam int unsigned NSYM  = PATTERN_LEN / BITS_PER_SYM;
  localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;

  typedef enum logic {
    MODE_PATTERN = 1'b0,
    MODE_PRBS    = 1'b1
  } mode_e;

  logic                    old_en;
  logic [PERIOD_W-1:0]     cntr;
  mode_e                   act_mode;
  mode_e                   mode_nx;
  logic [IDX_W-1:0]        idx;
  logic [PATTERN_LEN-1:0]  pat;
  logic [PATTERN_LEN-1:0]  pat_rot;
  logic [14:0]             lfsr;
  logic [14:0]             lfsr_nx;
  logic [BITS_PER_SYM-1:0] prbs_sym;
  logic [BITS_PER_SYM-1:0] sym;
  logic                    chg;
  logic                    frm;
  logic                    rise;
  logic                    step;
  logic                    idx_last;

  assign rise     = bus.enable_cntr & ~old_en;
  assign step     = rise && (cntr >= bus.period);
  assign idx_last = (idx == IDX_W'(NSYM - 1));
  assign mode_nx  = step ? mode_e'(bus.mode) : act_mode;

  // Shift form of the rotation stays legal when the pattern holds a single symbol.
  assign pat_rot = (pat << BITS_PER_SYM) | (pat >> (PATTERN_LEN - BITS_PER_SYM));

  always_comb begin
    lfsr_nx  = lfsr;
    prbs_sym = '0;
    for (int unsigned i = 0; i < BITS_PER_SYM; i++) begin
      lfsr_nx  = {lfsr_nx[13:0], lfsr_nx[14] ^ lfsr_nx[13]};
      prbs_sym = (prbs_sym << 1) | BITS_PER_SYM'(lfsr_nx[0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      old_en   <= 1'b1;
      cntr     <= '0;
      act_mode <= MODE_PATTERN;
      idx      <= '0;
      pat      <= PATTERN;
      lfsr     <= '1;
      sym      <= PATTERN[PATTERN_LEN-1 -: BITS_PER_SYM];
      chg      <= 1'b0;
      frm      <= 1'b0;
    end else begin
      old_en <= bus.enable_cntr;
      chg    <= step;
      frm    <= 1'b0;
      if (rise) begin
        cntr <= step ? '0 : cntr + PERIOD_W'(1);
      end
      if (step) begin
        act_mode <= mode_nx;
        if (mode_nx == MODE_PRBS) begin
          lfsr <= lfsr_nx;
          sym  <= prbs_sym;
        end else begin
          pat <= pat_rot;
          sym <= pat_rot[PATTERN_LEN-1 -: BITS_PER_SYM];
          idx <= idx_last ? '0 : idx + IDX_W'(1);
          frm <= idx_last;
        end
      end
    end
  end

  assign bus.sym_out     = sym;
  assign bus.data_change = chg;
  assign bus.frame_start = frm;
endmodule

// File: tb/tb_qam_symbol_gen.sv
// Scoreboard bench for qam_symbol_gen: a behavioural model queues the expected
// symbol/frame on each tick that steps; the monitor pops on every data_change.
module tb_qam_symbol_gen;
  localparam int unsigned B  = 2;
  localparam int unsigned PW = 10;
  localparam int unsigned PL = 28;
  localparam logic [PL-1:0] PAT = 28'h6CC1555;
  localparam int unsigned NSYM = PL / B;

  typedef struct packed {
    logic [B-1:0] sym;
    logic         frame;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  qam_symbol_gen_if #(.BITS_PER_SYM(B), .PERIOD_W(PW)) bus ();

  qam_symbol_gen #(
    .BITS_PER_SYM(B),
    .PERIOD_W    (PW),
    .PATTERN_LEN (PL),
    .PATTERN     (PAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int chg_cnt  = 0;
  int frm_cnt  = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];

  // model state
  int          m_cnt;
  int unsigned m_idx;
  logic [14:0] m_lfsr;
  logic [PL-1:0] m_pat;
  logic [B-1:0]  held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_lfsr = 15'h7FFF;
    m_pat  = PAT;
    held   = m_pat[PL-1 -: B];
    sb.delete();
  endtask

  task automatic model_tick();
    exp_t e;
    logic fb;
    if (m_cnt >= int'(bus.period)) begin
      m_cnt = 0;
      if (bus.mode) begin
        e.sym = '0;
        for (int k = 0; k < int'(B); k++) begin
          fb     = m_lfsr[14] ^ m_lfsr[13];
          m_lfsr = {m_lfsr[13:0], fb};
          e.sym  = {e.sym[B-2:0], fb};
        end
        e.frame = 1'b0;
      end else begin
        m_idx   = (m_idx + 1) % NSYM;
        e.sym   = m_pat[PL-1-m_idx*B -: B];
        e.frame = (m_idx == 0);
      end
      sb.push_back(e);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    @(posedge clock); #1;
    bus.enable_cntr = 1'b1;
    model_tick();
    @(posedge clock); #1;
    bus.enable_cntr = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    model_reset();
    idle(2);
    reset  = 1'b0;
    mon_en = 1'b1;
    chg_cnt = 0;
    frm_cnt = 0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (bus.data_change) begin
        chg_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_change", 32'(bus.sym_out), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          check("sym", 32'(bus.sym_out), 32'(e.sym));
          check("frame", 32'(bus.frame_start), 32'(e.frame));
          held = e.sym;
        end
      end else begin
        check("hold", 32'(bus.sym_out), 32'(held));
        check("frame_idle", 32'(bus.frame_start), 32'd0);
      end
      if (bus.frame_start) frm_cnt++;
    end
  end

  initial begin
    bus.enable_cntr = 1'b0;
    bus.mode        = 1'b0;
    bus.period      = '0;

    // reset state
    do_reset();
    @(negedge clock);
    check("rst_sym", 32'(bus.sym_out), 32'h1);
    check("rst_chg", 32'(bus.data_change), 32'd0);
    check("rst_frm", 32'(bus.frame_start), 32'd0);

    // pattern mode, one symbol per tick, full frame plus one
    bus.period = '0;
    bus.mode   = 1'b0;
    repeat (15) pulse();
    idle(2);
    check("t1_changes", 32'(chg_cnt), 32'd15);
    check("t1_frames", 32'(frm_cnt), 32'd1);
    check("t1_drain", 32'(sb.size()), 32'd0);

    // maximum period
    do_reset();
    bus.period = 10'd1023;
    repeat (2048) pulse();
    idle(2);
    check("t2_changes", 32'(chg_cnt), 32'd2);
    check("t2_drain", 32'(sb.size()), 32'd0);

    // PRBS from seed
    do_reset();
    bus.mode   = 1'b1;
    bus.period = '0;
    repeat (8) pulse();
    idle(2);
    check("t3_changes", 32'(chg_cnt), 32'd8);
    check("t3_frames", 32'(frm_cnt), 32'd0);
    check("t3_drain", 32'(sb.size()), 32'd0);

    // enable high through reset release
    bus.mode        = 1'b0;
    bus.enable_cntr = 1'b1;
    do_reset();
    idle(10);
    check("t4_no_count", 32'(chg_cnt), 32'd0);
    bus.enable_cntr = 1'b0;
    idle(1);
    pulse();
    idle(2);
    check("t4_first_rise", 32'(chg_cnt), 32'd1);
    check("t4_drain", 32'(sb.size()), 32'd0);

    // period lowered mid-count, mode toggled between steps
    do_reset();
    bus.period = 10'd20;
    repeat (10) pulse();
    idle(2);
    check("t5_pre", 32'(chg_cnt), 32'd0);
    bus.period = 10'd3;
    pulse();
    idle(2);
    check("t5_wrap", 32'(chg_cnt), 32'd1);
    pulse();
    bus.mode = 1'b1;
    pulse();
    bus.mode = 1'b0;
    pulse();
    pulse();
    bus.mode = 1'b1;
    repeat (3) pulse();
    pulse();
    idle(2);
    check("t5_changes", 32'(chg_cnt), 32'd3);
    check("t5_drain", 32'(sb.size()), 32'd0);

    // reset coincident with a step rise
    bus.mode = 1'b0;
    do_reset();
    bus.period = '0;
    repeat (3) pulse();
    idle(2);
    check("t6_pre", 32'(chg_cnt), 32'd3);
    mon_en = 1'b0;
    bus.enable_cntr = 1'b1;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("t6_sym", 32'(bus.sym_out), 32'h1);
    check("t6_chg", 32'(bus.data_change), 32'd0);
    check("t6_frm", 32'(bus.frame_start), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.enable_cntr = 1'b0;
    chg_cnt = 0;
    frm_cnt = 0;
    mon_en  = 1'b1;
    idle(1);
    pulse();
    idle(2);
    check("t6_restart", 32'(chg_cnt), 32'd1);
    check("t6_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/qam_symbol_gen.md
# qam_symbol_gen

Parametrised test-data source for the QAM modulator chain. It counts rising edges of a slow enable strobe and, every programmable number of edges, emits a new `BITS_PER_SYM`-bit symbol. The symbol comes from either a rotating fixed pattern or a PRBS15 sequence. It sits in front of the symbol mapper and replaces the single-bit, fixed-period generator with a multi-bit, multi-mode one.

## Interface
Parameters:
- `BITS_PER_SYM`, 2: bits per output symbol (2 = QPSK, 4 = 16-QAM, 6 = 64-QAM); must be 1..8.
- `PERIOD_W`, 10: width of the `period` input and the internal tick counter.
- `PATTERN_LEN`, 28: pattern length in bits; must be a multiple of `BITS_PER_SYM`.
- `PATTERN`, 28'h6CC1555: pattern reset value, MSB emitted first.

Ports:
- `clock` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable_cntr` input 1: tick strobe; only its rising edges count.
- `mode` input 1: 0 = pattern, 1 = PRBS15.
- `period` input `PERIOD_W`: number of ticks per symbol, minus 1.
- `sym_out` output `BITS_PER_SYM`: current symbol, held between updates.
- `data_change` output 1: one-clock pulse concurrent with a new `sym_out`.
- `frame_start` output 1: one-clock pulse when the pattern returns to symbol 0 (pattern mode only).

## Operation
- Edge detect:
  - `old_en` is a register that takes `enable_cntr` each clock; it is reset to 1, so a level that is already high at reset release does not count.
  - `rise = enable_cntr & !old_en`, evaluated combinationally against the current input.
- Tick counter (`PERIOD_W` bits):
  - On `rise`: if `cntr >= period`, then `cntr <= 0` and a symbol step occurs; otherwise `cntr <= cntr + 1`.
  - The `>=` compare means lowering `period` mid-count wraps on the next tick.
  - `period = 0` gives one symbol per tick.
- Active mode: `mode` is sampled only on a symbol step, into register `act_mode`; between steps changes to `mode` are ignored.
- Pattern mode step:
  - Rotate the `PATTERN_LEN` register left by `BITS_PER_SYM`.
  - The new `sym_out` is the top `BITS_PER_SYM` bits after rotation.
  - The symbol index (0..`PATTERN_LEN/BITS_PER_SYM - 1`) increments and wraps; on the wrap to 0, `frame_start` pulses.
- PRBS mode step:
  - LFSR is 15 bits, polynomial x^15+x^14+1, feedback `s[14]^s[13]` shifted in at the LSB.
  - The LFSR advances `BITS_PER_SYM` times per step (unrolled combinationally).
  - `sym_out` is the `BITS_PER_SYM` new bits, first-generated bit in the MSB.
- Only the active generator advances; the inactive one keeps its state, so switching back resumes where it left off.
- The LFSR seed is all ones; no all-zero lockup state is reachable.

## Timing
- Reset values:
  - `cntr` = 0; `old_en` = 1; `act_mode` = 0; symbol index = 0.
  - Pattern register = `PATTERN`; LFSR = 15'h7FFF.
  - `sym_out` = `PATTERN[PATTERN_LEN-1 -: BITS_PER_SYM]`.
  - `data_change` = 0; `frame_start` = 0.
- Update latency: on the clock edge where `rise` and `cntr >= period`, `sym_out`, `data_change` and `frame_start` all update at that same edge. The pulses stay high for exactly that one following cycle.
- Minimum symbol spacing is two clocks, because `enable_cntr` must fall and rise again.
- `reset` overrides everything, including a coincident `rise`. Reset mid-symbol discards the partial count and restarts the pattern at symbol 0.
- A `mode` change coincident with the step edge takes effect on that step.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, pattern mode, `BITS_PER_SYM=2`, `period=0`, 15 enable pulses -> `sym_out` reads 01 after reset, then 10,11,00,11,00,00,01,01,01,01,01,01,01 with one `data_change` per pulse. On pulse 14 it returns to 01 and `frame_start` pulses, and only on that step.
- `period=1023`, 2048 enable pulses -> exactly 2 `data_change` pulses, on ticks 1024 and 2048. `sym_out` is constant in between.
- PRBS mode from reset, `period=0`, `BITS_PER_SYM=2`, 8 pulses -> symbols 00 ×7, then 10 on pulse 8; `frame_start` never asserts.
- `enable_cntr` held high through reset release and for 10 clocks -> no count and no `data_change`. The first 0→1 transition afterwards counts as one tick.
- `period` lowered from 20 to 3 while `cntr=10` -> symbol step on the next rising edge, then every 4 ticks. Toggling `mode` mid-period has no effect until the next step.
- `reset` asserted on the same edge as a step `rise` -> `sym_out` = 01, `data_change` = 0, pattern restarts at symbol 0.
